// File: rtl/ram_word_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ram_word_responder
//  Purpose  : RAM-side endpoint of the word request stream. Every request
//             (read or write) is buffered in an in-order queue, executed
//             against an internal word-wide array after WAIT_CYCLES wait
//             states, and answered with a one-cycle ram_ack (plus read data).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   single clock (ram_clk domain)
//    rst        in   asynchronous, active-low reset
//    ram_aval   in   request valid, sampled every rising edge (no stall)
//    ram_rnw    in   1 = read, 0 = write
//    ram_addr   in   word address  [ADDR_WIDTH-1:0]
//    ram_wdata  in   write data    [WORD_WIDTH-1:0]
//    ram_rdata  out  read data, valid with ram_ack for reads
//    ram_ack    out  one-cycle completion pulse per accepted request
//    busy       out  queue non-empty or engine not idle
//    ovf        out  sticky: a request was dropped on a full queue
//    par_err    out  sticky parity error (RAM_RESPONDER_PARITY_EN only)
//
//  Build option
//    RAM_RESPONDER_PARITY_EN : array stores an even-parity bit per word and
//                              reads check it, reporting on par_err.
// ============================================================================
module ram_word_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WORD_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_aval,
    input  logic                  ram_rnw,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WORD_WIDTH-1:0] ram_wdata,
    output logic [WORD_WIDTH-1:0] ram_rdata,
    output logic                  ram_ack,
    output logic                  busy,
    output logic                  ovf
`ifdef RAM_RESPONDER_PARITY_EN
    ,
    output logic                  par_err
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_WAIT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int c_ENTRY_W = 1 + ADDR_WIDTH + WORD_WIDTH;
    localparam int c_MEM_DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_RESPONDER_PARITY_EN
    localparam int c_MEM_W = WORD_WIDTH + 1;
`else
    localparam int c_MEM_W = WORD_WIDTH;
`endif

    localparam logic [c_CNT_W-1:0]  c_QUEUE_FULL = c_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD  = c_WAIT_W'(WAIT_CYCLES);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE   = c_WAIT_W'(1);

    // Engine states
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_q_mem [QUEUE_DEPTH];
    logic [c_MEM_W-1:0]   r_mem   [c_MEM_DEPTH];

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_WAIT_W-1:0]   r_wait;
    logic                  r_op_rnw;
    logic [ADDR_WIDTH-1:0] r_op_addr;
    logic [WORD_WIDTH-1:0] r_op_wdata;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_ack;
    logic                  r_ovf;

    logic                  w_q_empty;
    logic                  w_q_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_do_access;
    logic                  w_ack_nxt;
    logic [c_ENTRY_W-1:0]  w_q_head;
    logic [c_MEM_W-1:0]    w_wr_word;
    logic [c_MEM_W-1:0]    w_rd_word;

    assign w_q_empty = (r_count == '0);
    assign w_q_full  = (r_count == c_QUEUE_FULL);
    assign w_q_head  = r_q_mem[r_rd_ptr];

    // A full queue still accepts when the engine pops on the same edge,
    // because the slot being vacated is reused immediately.
    assign w_push = ram_aval && (!w_q_full || w_pop);
    assign w_drop = ram_aval &&  w_q_full && !w_pop;

    // ------------------------------------------------------------------------
    // Request queue: circular buffer of {rnw, addr, wdata}
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_mem[r_wr_ptr] <= {ram_rnw, ram_addr, ram_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Engine FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Engine FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_wait == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // Chain straight into the next request without an IDLE bubble
                w_state_nxt = w_q_empty ? S_IDLE : S_ACCESS;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Engine FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_pop       = 1'b0;
        w_do_access = 1'b0;
        w_ack_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = !w_q_empty;
            end
            S_ACCESS: begin
                w_do_access = (r_wait == '0);
                w_ack_nxt   = (r_wait == '0);
            end
            S_RESP: begin
                w_pop = !w_q_empty;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operation registers and wait-state counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_rnw   <= 1'b0;
            r_op_addr  <= '0;
            r_op_wdata <= '0;
            r_wait     <= '0;
        end else begin
            if (w_pop) begin
                {r_op_rnw, r_op_addr, r_op_wdata} <= w_q_head;
                r_wait <= c_WAIT_LOAD;
            end else if ((r_state == S_ACCESS) && (r_wait != '0)) begin
                r_wait <= r_wait - c_WAIT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory array (not reset). Writes only happen from ACCESS, which an
    // asserted reset leaves immediately, so an aborted write never lands.
    // ------------------------------------------------------------------------
`ifdef RAM_RESPONDER_PARITY_EN
    // Stored bit makes the full word's XOR zero (even parity)
    assign w_wr_word = {^r_op_wdata, r_op_wdata};
`else
    assign w_wr_word = r_op_wdata;
`endif

    assign w_rd_word = r_mem[r_op_addr];

    always_ff @(posedge clk) begin
        if (w_do_access && !r_op_rnw) begin
            r_mem[r_op_addr] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------------
    // Response registers. Write acks leave ram_rdata untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_ack_nxt;
            if (w_do_access && r_op_rnw) begin
                r_rdata <= w_rd_word[WORD_WIDTH-1:0];
            end
        end
    end

`ifdef RAM_RESPONDER_PARITY_EN
    logic r_par_err;

    // A correctly stored word XORs to zero across data and parity bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (w_do_access && r_op_rnw && (^w_rd_word)) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ram_rdata = r_rdata;
    assign ram_ack   = r_ack;
    assign ovf       = r_ovf;
    assign busy      = !w_q_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_word_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_word_responder
//  Purpose  : Self-checking bench for ram_word_responder. A transaction-level
//             model predicts, for every accepted request, the edge at which
//             it is popped and acknowledged, plus the array contents, and a
//             compare process checks ack/busy/ovf/rdata every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_word_responder;

    localparam int AW = 12;
    localparam int WW = 8;
    localparam int QD = 16;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aval = 1'b0;
    logic          rnw = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [WW-1:0] wdata = '0;
    logic [WW-1:0] rdata;
    logic          ack;
    logic          busy;
    logic          ovf;
`ifdef RAM_RESPONDER_PARITY_EN
    logic          par_err;
`endif

    always #5 clk = ~clk;

    ram_word_responder #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .QUEUE_DEPTH(QD),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ram_aval (aval),
        .ram_rnw  (rnw),
        .ram_addr (addr),
        .ram_wdata(wdata),
        .ram_rdata(rdata),
        .ram_ack  (ack),
        .busy     (busy),
        .ovf      (ovf)
`ifdef RAM_RESPONDER_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: each accepted request gets a pop edge and an ack
    // edge. Pop happens one edge after acceptance or one edge after the
    // previous ack, whichever is later; ack follows WC+1 edges after pop.
    // ------------------------------------------------------------------------
    typedef struct {
        int            pop_e;
        int            ack_e;
        logic          rnw;
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } req_t;

    req_t          mq[$];
    logic [WW-1:0] mmem [2**AW];
    int            cyc = 0;
    int            last_ack = -10;
    logic          ovf_exp = 1'b0;
    logic [WW-1:0] rdata_exp = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            ovf_exp   = 1'b0;
            rdata_exp = '0;
            last_ack  = -10;
            if (clk) cyc++;
        end else begin
            int   pend;
            req_t r;
            cyc++;
            while (mq.size() > 0 && mq[0].ack_e < cyc) void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].ack_e == cyc) begin
                if (mq[0].rnw) rdata_exp = mmem[mq[0].a];
                else           mmem[mq[0].a] = mq[0].d;
            end
            if (aval) begin
                pend = 0;
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].pop_e > cyc) pend++;
                if (pend < QD) begin
                    r.pop_e = (last_ack + 1 > cyc + 1) ? last_ack + 1 : cyc + 1;
                    r.ack_e = r.pop_e + WC + 1;
                    r.rnw   = rnw;
                    r.a     = addr;
                    r.d     = wdata;
                    last_ack = r.ack_e;
                    mq.push_back(r);
                end else begin
                    ovf_exp = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process (falling edge, away from the active edge)
    // ------------------------------------------------------------------------
    int          ack_cyc_q[$];
    logic [WW-1:0] ack_dat_q[$];

    always @(negedge clk) begin
        logic exp_ack;
        exp_ack = (mq.size() > 0) && (mq[0].ack_e == cyc);
        check("ack",   32'(ack),   32'(exp_ack));
        check("busy",  32'(busy),  32'(mq.size() > 0));
        check("ovf",   32'(ovf),   32'(ovf_exp));
        check("rdata", 32'(rdata), 32'(rdata_exp));
        if (ack === 1'b1) begin
            ack_cyc_q.push_back(cyc);
            ack_dat_q.push_back(rdata);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic drive(input logic v, input logic r, input logic [AW-1:0] a, input logic [WW-1:0] d);
        @(negedge clk);
        #1;
        aval  = v;
        rnw   = r;
        addr  = a;
        wdata = d;
    endtask

    // Idle cycle with junk on the qualified fields
    task automatic idle();
        drive(1'b0, 1'($urandom), AW'($urandom), WW'($urandom));
    endtask

    task automatic wait_idle(input string name);
        int n;
        idle();
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin
            idle();
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        aval = 1'b0;
        rst  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed and random sequences
    // ------------------------------------------------------------------------
    initial begin
        int b;
        int e0;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Reset / idle
        repeat (20) idle();
        @(negedge clk);
        check("idle_ack",   32'(ack),   32'd0);
        check("idle_busy",  32'(busy),  32'd0);
        check("idle_ovf",   32'(ovf),   32'd0);
        check("idle_rdata", 32'(rdata), 32'd0);

        // Single write then read
        b = ack_cyc_q.size();
        drive(1'b1, 1'b0, 12'h005, 8'hA5);
        e0 = cyc + 1;
        wait_idle("single_wr_drain");
        drive(1'b1, 1'b1, 12'h005, 8'h00);
        wait_idle("single_rd_drain");
        check("single_ack_count", 32'(ack_cyc_q.size() - b), 32'd2);
        if (ack_cyc_q.size() - b == 2) begin
            check("single_wr_latency", 32'(ack_cyc_q[b] - e0), 32'd4);
            check("single_rd_data",    32'(ack_dat_q[b+1]),    32'hA5);
        end

        // Burst of 16 writes, then 16 reads
        b = ack_cyc_q.size();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, AW'(12'h010 + i), WW'(i));
        wait_idle("burst_wr_drain");
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, AW'(12'h010 + i), 8'h00);
        wait_idle("burst_rd_drain");
        check("burst_ack_count", 32'(ack_cyc_q.size() - b), 32'd32);
        check("burst_ovf", 32'(ovf), 32'd0);
        if (ack_cyc_q.size() - b == 32) begin
            for (int i = 0; i < 16; i++)
                check("burst_rd_data", 32'(ack_dat_q[b+16+i]), 32'(i));
            for (int i = 1; i < 16; i++) begin
                check("burst_wr_spacing", 32'(ack_cyc_q[b+i] - ack_cyc_q[b+i-1]), 32'd4);
                check("burst_rd_spacing", 32'(ack_cyc_q[b+16+i] - ack_cyc_q[b+15+i]), 32'd4);
            end
        end

        // Initialise a working set, then random traffic over it
        for (int a = 0; a < 64; a++) drive(1'b1, 1'b0, AW'(a), WW'($urandom));
        wait_idle("init_drain");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0)
                drive(1'b1, 1'($urandom), AW'($urandom_range(0, 63)), WW'($urandom));
            else
                idle();
        end
        wait_idle("random_drain");

        // Write immediately followed by read of the same address
        b = ack_cyc_q.size();
        drive(1'b1, 1'b0, 12'h02A, 8'h3C);
        drive(1'b1, 1'b1, 12'h02A, 8'h00);
        wait_idle("wr_rd_drain");
        if (ack_cyc_q.size() - b == 2)
            check("wr_then_rd_data", 32'(ack_dat_q[b+1]), 32'h3C);
        else
            check("wr_then_rd_count", 32'(ack_cyc_q.size() - b), 32'd2);

        // Overflow: long run of back-to-back requests
        b = ack_cyc_q.size();
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, AW'(12'h040 + i), WW'(i));
        wait_idle("ovf_drain");
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_acks_lt_30", 32'((ack_cyc_q.size() - b) < 30), 32'd1);

        // Reset clears sticky overflow
        do_reset();
        @(negedge clk);
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Reset mid-burst: queued and in-flight writes are discarded
        drive(1'b1, 1'b0, 12'h020, 8'h11);
        wait_idle("pre_abort_drain");
        b = ack_cyc_q.size();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 12'h020, 8'hEE);
        do_reset();
        repeat (20) idle();
        check("abort_no_acks", 32'(ack_cyc_q.size() - b), 32'd0);
        drive(1'b1, 1'b1, 12'h020, 8'h00);
        wait_idle("post_abort_drain");
        if (ack_cyc_q.size() - b == 1)
            check("abort_array_intact", 32'(ack_dat_q[b]), 32'h11);
        else
            check("post_abort_ack_count", 32'(ack_cyc_q.size() - b), 32'd1);

        // Parity: corrupt stored word at 0x07 then read it
        b = ack_cyc_q.size();
`ifdef RAM_RESPONDER_PARITY_EN
        check("par_err_clear", 32'(par_err), 32'd0);
        dut.r_mem[7][WW] = ~dut.r_mem[7][WW];
`endif
        drive(1'b1, 1'b1, 12'h007, 8'h00);
        wait_idle("parity_drain");
        check("parity_read_acked", 32'(ack_cyc_q.size() - b), 32'd1);
`ifdef RAM_RESPONDER_PARITY_EN
        check("par_err_set", 32'(par_err), 32'd1);
`endif

        repeat (3) idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
